// File: rtl/lc3b_hazard_scoreboard_pkg.sv
// Shared types and constants for the LC-3b hazard scoreboard.
package lc3b_hazard_scoreboard_pkg;

    localparam int unsigned LC3B_NUM_REGS = 8;
    localparam int unsigned LC3B_REG_W    = 3;
    localparam int unsigned LC3B_STAT_W   = 16;

    typedef logic [LC3B_REG_W-1:0] lc3b_reg;

    typedef enum logic [0:0] {
        SB_RUN      = 1'b0,
        SB_MEM_WAIT = 1'b1
    } lc3b_sb_state_t;

    // Saturating increment used by the optional statistics counters.
    function automatic logic [LC3B_STAT_W-1:0] stat_inc(
        input logic [LC3B_STAT_W-1:0] v,
        input logic                   en
    );
        return (en && (v != '1)) ? v + LC3B_STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/lc3b_sb_counter.sv
// Per-register in-flight writer counter: saturating up/down with a busy flag.
module lc3b_sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Coincident inc/dec cancel; overflow and underflow hold the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc && !dec && (cnt == CNT_MAX)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !inc && (cnt == '0)));

endmodule

// File: rtl/lc3b_hazard_scoreboard.sv
// LC-3b pipeline interlock: load-use bubble, memory-wait freeze, in-flight writer tracking.
// Optional macro LC3B_SCOREBOARD_STATS_EN adds stall_cycles and load_use_count outputs.
module lc3b_hazard_scoreboard
    import lc3b_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = LC3B_NUM_REGS,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  lc3b_reg                id_src1,
    input  lc3b_reg                id_src2,
    input  logic                   id_src1_used,
    input  logic                   id_src2_used,
    input  lc3b_reg                id_dest,
    input  logic                   id_writes_reg,
    input  logic                   id_is_load,
    input  logic                   mem_req,
    input  logic                   mem_resp,
    input  logic                   wb_valid,
    input  logic                   wb_writes_reg,
    input  lc3b_reg                wb_dest,
`ifdef LC3B_SCOREBOARD_STATS_EN
    output logic [LC3B_STAT_W-1:0] stall_cycles,
    output logic [LC3B_STAT_W-1:0] load_use_count,
`endif
    output logic                   stall_fetch,
    output logic                   bubble_ex,
    output logic                   stall_pipe,
    output logic [NUM_REGS-1:0]    reg_busy
);

    lc3b_sb_state_t state, state_next;
    logic           ld_ex_valid;
    lc3b_reg        ld_ex_dest;
    logic           load_use;
    logic           advance;
    logic           issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SB_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A dropped mem_req without mem_resp is a protocol error; keep waiting.
    always_comb begin
        state_next = state;
        stall_pipe = 1'b0;
        case (state)
            SB_RUN: begin
                stall_pipe = mem_req & ~mem_resp;
                if (mem_req && !mem_resp) begin
                    state_next = SB_MEM_WAIT;
                end
            end
            SB_MEM_WAIT: begin
                stall_pipe = ~mem_resp;
                if (mem_resp) begin
                    state_next = SB_RUN;
                end
            end
            default: begin
                state_next = SB_RUN;
            end
        endcase
    end

    assign load_use = id_valid & ld_ex_valid &
                      ((id_src1_used & (id_src1 == ld_ex_dest)) |
                       (id_src2_used & (id_src2 == ld_ex_dest)));

    assign advance     = ~stall_pipe;
    assign issue       = advance & id_valid & ~load_use;
    assign bubble_ex   = load_use & ~stall_pipe;
    assign stall_fetch = load_use | stall_pipe;

    // Tracks the load now in EX; a bubble clears it so load-use costs one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ex_valid <= 1'b0;
            ld_ex_dest  <= '0;
        end else if (advance) begin
            ld_ex_valid <= issue & id_is_load & id_writes_reg;
            ld_ex_dest  <= id_dest;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        logic inc_r;
        logic dec_r;

        assign inc_r = issue & id_writes_reg & (id_dest == LC3B_REG_W'(r));
        assign dec_r = advance & wb_valid & wb_writes_reg & (wb_dest == LC3B_REG_W'(r));

        lc3b_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_r),
            .dec   (dec_r),
            .busy  (reg_busy[r])
        );
    end

`ifdef LC3B_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles   <= '0;
            load_use_count <= '0;
        end else begin
            stall_cycles   <= stat_inc(stall_cycles, stall_pipe);
            load_use_count <= stat_inc(load_use_count, bubble_ex);
        end
    end
`endif

endmodule

// File: tb/tb_lc3b_hazard_scoreboard.sv
// Scoreboard bench for lc3b_hazard_scoreboard: directed cycles push expectations, a monitor compares.
module tb_lc3b_hazard_scoreboard;

    typedef struct {
        string      nm;
        logic       bubble;
        logic       sfetch;
        logic       spipe;
        logic [7:0] busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [2:0] id_src1 = '0;
    logic [2:0] id_src2 = '0;
    logic       id_src1_used = 1'b0;
    logic       id_src2_used = 1'b0;
    logic [2:0] id_dest = '0;
    logic       id_writes_reg = 1'b0;
    logic       id_is_load = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_resp = 1'b0;
    logic       wb_valid = 1'b0;
    logic       wb_writes_reg = 1'b0;
    logic [2:0] wb_dest = '0;
    logic       stall_fetch;
    logic       bubble_ex;
    logic       stall_pipe;
    logic [7:0] reg_busy;
`ifdef LC3B_SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] load_use_count;
`endif

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic done     = 1'b0;

    always #5 clk = ~clk;

    lc3b_hazard_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_src1_used   (id_src1_used),
        .id_src2_used   (id_src2_used),
        .id_dest        (id_dest),
        .id_writes_reg  (id_writes_reg),
        .id_is_load     (id_is_load),
        .mem_req        (mem_req),
        .mem_resp       (mem_resp),
        .wb_valid       (wb_valid),
        .wb_writes_reg  (wb_writes_reg),
        .wb_dest        (wb_dest),
`ifdef LC3B_SCOREBOARD_STATS_EN
        .stall_cycles   (stall_cycles),
        .load_use_count (load_use_count),
`endif
        .stall_fetch    (stall_fetch),
        .bubble_ex      (bubble_ex),
        .stall_pipe     (stall_pipe),
        .reg_busy       (reg_busy)
    );

    // One cycle: drive inputs just after the rising edge and queue the expected outputs.
    task automatic cyc(
        input string      nm,
        input logic       rs,
        input logic       iv,
        input logic [2:0] s1, input logic u1,
        input logic [2:0] s2, input logic u2,
        input logic [2:0] d,  input logic wr, input logic ld,
        input logic       mq, input logic mr,
        input logic       wv, input logic [2:0] wd,
        input logic       eb, input logic esf, input logic esp,
        input logic [7:0] ebusy
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = rs;
        id_valid      = iv;
        id_src1       = s1;
        id_src1_used  = u1;
        id_src2       = s2;
        id_src2_used  = u2;
        id_dest       = d;
        id_writes_reg = wr;
        id_is_load    = ld;
        mem_req       = mq;
        mem_resp      = mr;
        wb_valid      = wv;
        wb_writes_reg = wv;
        wb_dest       = wd;
        e.nm = nm; e.bubble = eb; e.sfetch = esf; e.spipe = esp; e.busy = ebusy;
        exp_q.push_back(e);
    endtask

    // Monitor: compare at the falling edge, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bubble_ex !== e.bubble) begin
                    failures++;
                    $display("FAIL %s: got bubble_ex=%b, want %b", e.nm, bubble_ex, e.bubble);
                end
                if (stall_fetch !== e.sfetch) begin
                    failures++;
                    $display("FAIL %s: got stall_fetch=%b, want %b", e.nm, stall_fetch, e.sfetch);
                end
                if (stall_pipe !== e.spipe) begin
                    failures++;
                    $display("FAIL %s: got stall_pipe=%b, want %b", e.nm, stall_pipe, e.spipe);
                end
                if (reg_busy !== e.busy) begin
                    failures++;
                    $display("FAIL %s: got reg_busy=%h, want %h", e.nm, reg_busy, e.busy);
                end
            end else if (done) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        //   name          rs iv s1 u1 s2 u2 d  wr ld mq mr wv wd   b  sf sp busy
        cyc("reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("release",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        // load-use bubble on R3
        cyc("ldr_r3",      1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("lu_bubble",   1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0,   1, 1, 0, 8'h08);
        cyc("lu_clear",    1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0,   0, 0, 0, 8'h08);
        cyc("wb_r3",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0, 8'h18);
        cyc("wb_r4",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 8'h10);
        cyc("lu_idle",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        // non-load producer: no bubble, busy tracks issue/retire
        cyc("add_r3",      1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("use_r3",      1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h08);
        cyc("add_wb",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 0, 0, 8'h08);
        cyc("add_done",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        // memory wait: 3 stalled cycles, resp cycle free, back in RUN
        cyc("mw_1",        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 1, 8'h00);
        cyc("mw_2",        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 1, 8'h00);
        cyc("mw_3",        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 1, 8'h00);
        cyc("mw_resp",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 8'h00);
        cyc("mw_run",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("mw_hit",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 8'h00);
        // load-use under memory stall: bubble deferred to resp cycle
        cyc("ldr_r2",      1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("hs_stall1",   1, 1, 2, 1, 0, 0, 5, 1, 0, 1, 0, 0, 0,   0, 1, 1, 8'h04);
        cyc("hs_stall2",   1, 1, 2, 1, 0, 0, 5, 1, 0, 1, 0, 0, 0,   0, 1, 1, 8'h04);
        cyc("hs_bubble",   1, 1, 2, 1, 0, 0, 5, 1, 0, 1, 1, 0, 0,   1, 1, 0, 8'h04);
        cyc("hs_issue",    1, 1, 2, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 0, 8'h04);
        cyc("hs_wb_r2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,   0, 0, 0, 8'h24);
        cyc("hs_after",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h20);
        // coincident issue and retire of R5 with cnt[5]=1
        cyc("co_both",     1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 5,   0, 0, 0, 8'h20);
        cyc("co_wb",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   0, 0, 0, 8'h20);
        cyc("co_empty",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        // cnt[2]=2, enter MEM_WAIT (retire blocked), then async reset
        cyc("rs_iss1",     1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("rs_iss2",     1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0,   0, 0, 0, 8'h04);
        cyc("rs_wait1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2,   0, 1, 1, 8'h04);
        cyc("rs_wait2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 1, 8'h04);
        cyc("rs_assert",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("rs_release",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("rs_ldr_r1",   1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("rs_bubble",   1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 8'h02);
        cyc("rs_clear",    1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h02);
        cyc("rs_wb_r1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 8'h02);
        cyc("rs_done",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        // R0 is an ordinary register for load-use
        cyc("ldr_r0",      1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        cyc("r0_bubble",   1, 1, 0, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0,   1, 1, 0, 8'h01);
        cyc("r0_clear",    1, 1, 0, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h01);
        cyc("r0_wb",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 8'h01);
        cyc("r0_done",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00);
        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule

// File: doc/lc3b_hazard_scoreboard.md
# lc3b_hazard_scoreboard

Pipeline interlock for the LC-3b five-stage core, complementing data forwarding. Forwarding repairs stale operands after the fact; this block stalls whenever forwarding cannot. It tracks in-flight register writers from issue (ID→EX) to retirement (WB), inserts a one-cycle bubble on load-use hazards, and freezes the whole pipeline while the MEM stage waits on the memory handshake.

## Interface
Parameters:
- NUM_REGS, 8, architectural register count; index width is lc3b_reg
- CNT_W, 2, per-register in-flight writer counter width (max 3 writers: EX, MEM, WB)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src1 / id_src2  in  lc3b_reg  ID source registers
- id_src1_used / id_src2_used  in  1  source actually read
- id_dest  in  lc3b_reg  ID destination
- id_writes_reg  in  1  ID instruction writes the regfile
- id_is_load  in  1  ID instruction is LDR/LDB/LDI
- mem_req  in  1  MEM stage holds an active memory access
- mem_resp  in  1  memory completed this cycle
- wb_valid / wb_writes_reg  in  1  WB retiring a regfile write
- wb_dest  in  lc3b_reg  WB destination
- stall_fetch  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX instead of ID contents
- stall_pipe  out  1  freeze all pipeline registers
- reg_busy  out  NUM_REGS  bit r set while counter r ≠ 0

## Operation
- Memory FSM, states RUN, MEM_WAIT.
  - RUN: mem_req & !mem_resp → MEM_WAIT; otherwise stay.
  - MEM_WAIT: mem_resp → RUN; otherwise stay. mem_req dropping without mem_resp is a protocol error; stay in MEM_WAIT.
  - stall_pipe = mem_req & !mem_resp in RUN; !mem_resp in MEM_WAIT.
- Load tracker: registers ld_ex_valid and ld_ex_dest describe the load currently in EX.
- load_use = id_valid & ld_ex_valid & ((id_src1_used & id_src1==ld_ex_dest) | (id_src2_used & id_src2==ld_ex_dest)).
- bubble_ex = load_use & !stall_pipe.
- stall_fetch = load_use | stall_pipe.
- advance = !stall_pipe. issue = advance & id_valid & !load_use.
- On advance:
  - ld_ex_valid ← issue & id_is_load & id_writes_reg
  - ld_ex_dest ← id_dest
- On stall_pipe: tracker holds.
- Counters: cnt[r] increments on issue & id_writes_reg & id_dest==r. It decrements on advance & wb_valid & wb_writes_reg & wb_dest==r.
- Simultaneous increment and decrement of the same r leaves the count unchanged.
- Increment at 3 saturates; decrement at 0 holds. Both are simulation assertion failures.
- A load to R0 followed by a consumer of R0 stalls like any other register; there is no hardwired zero register.

## Timing
- Reset (rst_n low, async): state RUN, ld_ex_valid 0, ld_ex_dest 0, all cnt 0. Outputs are then 0 given id_valid=0 and mem_req=0.
- Reset asserted mid-stall clears the state immediately. First cycle after release is RUN with no tracked loads.
- Outputs are combinational from registered state and current inputs, so the stall or bubble takes effect in the same cycle as the hazard.
- Load-use costs exactly 1 bubble: the next cycle ld_ex_valid is 0, so the hazard clears.
- Memory stall lasts until the mem_resp cycle inclusive-exclusive. The pipeline advances on the edge ending the mem_resp cycle.
- Load-use during stall_pipe: bubble_ex stays 0, stall_fetch 1. The bubble is applied on the first non-stalled cycle.
- reg_busy updates one cycle after issue/retire.

## Configuration
- LC3B_SCOREBOARD_STATS_EN defined: adds outputs stall_cycles[15:0] and load_use_count[15:0].
  - stall_cycles counts cycles with stall_pipe.
  - load_use_count counts cycles with bubble_ex.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Add to lc3b_types: enum lc3b_sb_state_t {SB_RUN, SB_MEM_WAIT}; constant LC3B_NUM_REGS = 8.
- Sub-module lc3b_sb_counter: one CNT_W saturating up/down counter with busy flag, instantiated NUM_REGS times.
- Top level holds the FSM, load tracker, hazard compare and stats.

## Test plan
- Load-use bubble: issue LDR R3 (id_is_load=1, id_dest=3), next cycle ID reads R3 via src1 → bubble_ex=1, stall_fetch=1 for exactly 1 cycle, then 0.
- Non-load producer: ADD R3, then consumer of R3 → no bubble; reg_busy[3]=1 one cycle after issue and 0 one cycle after its WB.
- Memory wait: mem_req=1, mem_resp=0 for 3 cycles, then mem_resp=1 → stall_pipe=1 for 3 cycles, 0 in the resp cycle; state returns to RUN.
- Hazard under memory stall: load in EX, dependent in ID, mem_req held 2 cycles → bubble_ex=0 while stalled; bubble_ex=1 on the first free cycle.
- Counter coincidence: R5 issue and R5 WB retire in the same cycle with cnt[5]=1 → cnt stays 1, reg_busy[5]=1.
- Async reset mid-MEM_WAIT with cnt[2]=2 → all outputs and reg_busy go 0 immediately; normal operation resumes after rst_n rises.
